toeplitz_hash_core: RTL and testbench
=====================================

Name: toeplitz_hash_core

Overview:
- Parametrised streaming Toeplitz hash engine for privacy amplification.
- Multiplies an IN_LEN-bit input block by an OUT_W x IN_LEN Toeplitz matrix over GF(2).
- The matrix is defined by a serial seed stream of OUT_W+IN_LEN-1 bits.
- Successor to the fixed-width row-generate/row-sum pair:
  - Width and block length are parameters.
  - Data and seed arrive on valid/ready handshakes with stall support.
  - The result is held under output backpressure.

Parameters:
- OUT_W, 3072: hash output width in bits, i.e. the row register width; must be >= 2.
- IN_LEN, 8192: input bits per block, i.e. accumulate beats per hash; must be >= 2.
- CNT_W, 16: width of the internal beat/preload counter; must satisfy 2^CNT_W > max(OUT_W, IN_LEN).

Ports:
- clk_in, in, 1: clock; all state changes on the rising edge.
- rst, in, 1: reset, asynchronous, active-low.
- start, in, 1: single-cycle pulse that begins a block; honoured only in IDLE.
- seed_bit, in, 1: next Toeplitz seed bit.
- seed_valid, in, 1: seed_bit is valid.
- seed_ready, out, 1: core accepts seed_bit this cycle.
- data_bit, in, 1: next input (coefficient) bit.
- data_valid, in, 1: data_bit is valid.
- data_ready, out, 1: core accepts data_bit this cycle.
- busy, out, 1: high in any state other than IDLE.
- result, out, OUT_W: hash value; stable while result_valid=1.
- result_valid, out, 1: result is available.
- result_ready, in, 1: downstream accepts result.

Behaviour:
- Reset values (rst=0, asynchronous): state=IDLE; window=0; acc=0; cnt=0.
  - All outputs 0: seed_ready, data_ready, busy, result_valid, result.
- State IDLE:
  - On start=1: go to PRELOAD, cnt<=0, acc<=0.
  - start in any other state is ignored.
- State PRELOAD:
  - seed_ready=1, data_ready=0.
  - Each seed handshake: window <= {window[OUT_W-2:0], seed_bit}, cnt++.
  - After the OUT_W-th seed bit: go to ACCUM, cnt<=0.
- State ACCUM:
  - last = (cnt == IN_LEN-1).
  - data_ready = last ? 1 : seed_valid.
  - seed_ready = !last && data_valid.
  - A beat fires when data_valid && (last || seed_valid). Data and seed are consumed together; a seed is never consumed without a data bit, and vice versa.
  - On a beat, if data_bit=1: acc <= acc ^ window (XOR uses the pre-shift window).
  - On a non-last beat: window shifts in seed_bit as in PRELOAD, cnt++.
  - On the last beat: no seed is consumed; go to DONE; result <= the final acc value, including this beat's XOR.
- State DONE:
  - result_valid=1; result and acc are frozen.
  - On result_ready=1: go to IDLE and drop result_valid the next cycle.
  - result keeps its value in IDLE until the next block's DONE.
- Seed consumption: exactly OUT_W+IN_LEN-1 seed bits and IN_LEN data bits per block.
- Latency: result_valid rises on the cycle after the last data beat. Minimum block time with no stalls is OUT_W+IN_LEN+1 cycles from start.
- Stalls:
  - A deasserted valid freezes window, acc and cnt.
  - In ACCUM with data_valid=1 and seed_valid=0 (non-last): no beat fires and data_ready=0.
- Combinational paths: ready outputs may depend combinationally on the opposite valid. They must not depend on their own valid.
- Reset mid-operation: aborts immediately to IDLE with all state cleared; a partial block is discarded, never emitted.

Test Plan:
- OUT_W=8, IN_LEN=4:
  - start; seed 1,0,1,1,0,0,1,0 (window=0xB2).
  - Then data 1,0,0,1 paired with seed 1,1,0; last beat takes data only.
  - Expected: result=0x24 with result_valid=1, and exactly 11 seed and 4 data handshakes.
- Same seed, data 0,0,0,0 -> result=0x00. Data 1,1,1,1 with seed tail 1,1,0 -> result=0xB2^0x65^0xCB^0x96=0x8A.
- Stalls: repeat the first case with seed_valid and data_valid toggled pseudo-randomly and independently -> result still 0x24, and no handshake on one side without the other in ACCUM.
- Backpressure: hold result_ready=0 for 20 cycles in DONE and pulse start -> result stays 0x24, result_valid stays 1, start is ignored. Raise result_ready -> IDLE the next cycle.
- Reset: drop rst mid-ACCUM (after 2 beats) -> all outputs 0 asynchronously. A fresh full block afterwards gives 0x24.
- Default parameters (3072/8192): random seed and data vs the bench reference model -> bit-exact result and seed count 11263.

Source files
------------

// File: rtl/toeplitz_hash_if.sv
// toeplitz_hash_if: start, seed/data valid-ready streams and held result handshake
interface toeplitz_hash_if #(
    parameter int OUT_W = 3072
) ();
    logic             start;
    logic             seed_bit;
    logic             seed_valid;
    logic             seed_ready;
    logic             data_bit;
    logic             data_valid;
    logic             data_ready;
    logic             busy;
    logic [OUT_W-1:0] result;
    logic             result_valid;
    logic             result_ready;

    modport master (
        output start, seed_bit, seed_valid, data_bit, data_valid, result_ready,
        input  seed_ready, data_ready, busy, result, result_valid
    );

    modport slave (
        input  start, seed_bit, seed_valid, data_bit, data_valid, result_ready,
        output seed_ready, data_ready, busy, result, result_valid
    );
endinterface

// File: rtl/toeplitz_hash_core.sv
// toeplitz_hash_core: streaming GF(2) Toeplitz matrix-vector hash driven by a serial seed
module toeplitz_hash_core #(
    parameter int OUT_W  = 3072,
    parameter int IN_LEN = 8192,
    parameter int CNT_W  = 16
) (
    input logic             clk_in,
    input logic             rst,
    toeplitz_hash_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PRELOAD, ACCUM, DONE} state_t;

    state_t           state;
    logic [OUT_W-1:0] window;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] result_q;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             seed_hs;
    logic             beat;
    logic [OUT_W-1:0] acc_next;

    // Handshake decode: in ACCUM seed and data are only ever consumed together, except the last beat
    always_comb begin
        last            = (state == ACCUM) && (cnt == CNT_W'(IN_LEN - 1));
        bus.seed_ready  = (state == PRELOAD) || ((state == ACCUM) && !last && bus.data_valid);
        bus.data_ready  = (state == ACCUM) && (last || bus.seed_valid);
        seed_hs         = bus.seed_valid && bus.seed_ready;
        beat            = (state == ACCUM) && bus.data_valid && bus.data_ready;
        acc_next        = acc ^ (window & {OUT_W{bus.data_bit}});
        bus.busy        = (state != IDLE);
        bus.result_valid = (state == DONE);
        bus.result      = result_q;
    end

    // Block sequencer: preload the first matrix row, accumulate selected rows, then hold the result
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            window   <= '0;
            acc      <= '0;
            result_q <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state <= PRELOAD;
                    cnt   <= '0;
                    acc   <= '0;
                end
                PRELOAD: if (seed_hs) begin
                    window <= {window[OUT_W-2:0], bus.seed_bit};
                    if (cnt == CNT_W'(OUT_W - 1)) begin
                        state <= ACCUM;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACCUM: if (beat) begin
                    acc <= acc_next;
                    if (last) begin
                        state    <= DONE;
                        result_q <= acc_next;
                    end else begin
                        window <= {window[OUT_W-2:0], bus.seed_bit};
                        cnt    <= cnt + 1'b1;
                    end
                end
                DONE: if (bus.result_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_toeplitz_hash_core.sv
// tb_toeplitz_hash_core: scenario tasks against a matrix-product reference model, small and default sizes
module tb_toeplitz_hash_core;
    localparam int BW = 3072;
    localparam int BL = 8192;

    logic clk_in = 0;
    logic rst = 0;
    logic sb = 0, sv = 0, db = 0, dv = 0, rr = 0, st_s = 0, st_b = 0, sel = 0;
    int   pass = 0, total = 0;

    toeplitz_hash_if #(.OUT_W(8)) si ();
    toeplitz_hash_if #(.OUT_W(BW)) bi ();

    toeplitz_hash_core #(.OUT_W(8), .IN_LEN(4), .CNT_W(4)) dut_s (.clk_in(clk_in), .rst(rst), .bus(si.slave));
    toeplitz_hash_core #(.OUT_W(BW), .IN_LEN(BL), .CNT_W(16)) dut_b (.clk_in(clk_in), .rst(rst), .bus(bi.slave));

    assign si.start = st_s;
    assign si.seed_bit = sb;
    assign si.seed_valid = sv;
    assign si.data_bit = db;
    assign si.data_valid = dv;
    assign si.result_ready = rr;
    assign bi.start = st_b;
    assign bi.seed_bit = sb;
    assign bi.seed_valid = sv;
    assign bi.data_bit = db;
    assign bi.data_valid = dv;
    assign bi.result_ready = rr;

    wire sr = sel ? bi.seed_ready : si.seed_ready;
    wire dr = sel ? bi.data_ready : si.data_ready;
    wire rv = sel ? bi.result_valid : si.result_valid;

    always #5 clk_in = ~clk_in;

    // Row i (MSB first) of the Toeplitz matrix at column j is seed bit j+i
    function automatic logic [BW-1:0] model(input bit s[$], input bit d[$], input int ow);
        logic [BW-1:0] r = '0;
        for (int j = 0; j < d.size(); j++)
            if (d[j]) for (int k = 0; k < ow; k++) r[ow-1-k] = r[ow-1-k] ^ s[j+k];
        return r;
    endfunction

    task automatic run_block(input bit big, input bit sq_in[$], input bit dq_in[$], input bit stall,
                             input bit wait_res, output int ns, output int nd, output int viol,
                             output int cyc, output bit got);
        bit sq[$];
        bit dq[$];
        bit shs, dhs;
        int ow, il, budget;
        sq = sq_in;
        dq = dq_in;
        ow = big ? BW : 8;
        il = big ? BL : 4;
        ns = 0; nd = 0; viol = 0; cyc = 0; got = 0;
        sel = big;
        @(negedge clk_in);
        sv = 0; dv = 0;
        if (big) st_b = 1; else st_s = 1;
        @(posedge clk_in);
        cyc = 1;
        @(negedge clk_in);
        st_s = 0; st_b = 0;
        budget = 4 * (sq_in.size() + dq_in.size()) + 100;
        while ((sq.size() > 0 || dq.size() > 0) && budget > 0) begin
            sv = (sq.size() > 0) && (!stall || $urandom_range(0, 2) != 0);
            dv = (dq.size() > 0) && (!stall || $urandom_range(0, 2) != 0);
            sb = 0; db = 0;
            if (sq.size() > 0) sb = sq[0];
            if (dq.size() > 0) db = dq[0];
            #4;
            shs = sv && sr;
            dhs = dv && dr;
            if (shs && ns >= ow && !dhs) viol++;
            if (dhs && !shs && nd != il - 1) viol++;
            @(posedge clk_in);
            cyc++;
            budget--;
            if (shs) begin void'(sq.pop_front()); ns++; end
            if (dhs) begin void'(dq.pop_front()); nd++; end
            @(negedge clk_in);
        end
        sv = 0; dv = 0;
        if (wait_res) begin
            budget = 100;
            while (!rv && budget > 0) begin
                @(negedge clk_in);
                budget--;
            end
            got = rv;
        end
    endtask

    task automatic release_res();
        @(negedge clk_in);
        rr = 1;
        @(negedge clk_in);
        rr = 0;
    endtask

    task automatic base_seed(output bit s[$]);
        s = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 0};
    endtask

    task automatic test_reset();
        #1;
        total++; if (si.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", si.busy); else pass++;
        total++; if (si.seed_ready !== 1'b0) $display("FAIL reset_seed_ready: got %b want 0", si.seed_ready); else pass++;
        total++; if (si.data_ready !== 1'b0) $display("FAIL reset_data_ready: got %b want 0", si.data_ready); else pass++;
        total++; if (si.result_valid !== 1'b0) $display("FAIL reset_result_valid: got %b want 0", si.result_valid); else pass++;
        total++; if (si.result !== 8'h00) $display("FAIL reset_result: got %h want 00", si.result); else pass++;
        @(negedge clk_in);
        rst = 1;
    endtask

    task automatic test_basic();
        bit s[$];
        bit d[$];
        int ns, nd, viol, cyc;
        bit got;
        logic [BW-1:0] e;
        base_seed(s);
        d = '{1, 0, 0, 1};
        e = model(s, d, 8);
        run_block(0, s, d, 0, 1, ns, nd, viol, cyc, got);
        total++; if (!got) $display("FAIL basic_valid: got %b want 1", got); else pass++;
        total++; if (si.result !== 8'h24) $display("FAIL basic_result: got %h want 24", si.result); else pass++;
        total++; if (si.result !== e[7:0]) $display("FAIL basic_model: got %h want %h", si.result, e[7:0]); else pass++;
        total++; if (ns != 11 || nd != 4) $display("FAIL basic_counts: got %0d/%0d want 11/4", ns, nd); else pass++;
        total++; if (cyc != 13) $display("FAIL basic_latency: got %0d want 13", cyc); else pass++;
        total++; if (viol != 0) $display("FAIL basic_pairing: got %0d want 0", viol); else pass++;
        release_res();
    endtask

    task automatic test_patterns();
        bit s[$];
        bit d[$];
        int ns, nd, viol, cyc;
        bit got;
        base_seed(s);
        d = '{0, 0, 0, 0};
        run_block(0, s, d, 0, 1, ns, nd, viol, cyc, got);
        total++; if (!got || si.result !== 8'h00) $display("FAIL zeros_result: got %h valid %b want 00", si.result, got); else pass++;
        release_res();
        d = '{1, 1, 1, 1};
        run_block(0, s, d, 0, 1, ns, nd, viol, cyc, got);
        total++; if (!got || si.result !== 8'h8A) $display("FAIL ones_result: got %h valid %b want 8a", si.result, got); else pass++;
        release_res();
    endtask

    task automatic test_stall();
        bit s[$];
        bit d[$];
        int ns, nd, viol, cyc;
        bit got;
        base_seed(s);
        d = '{1, 0, 0, 1};
        run_block(0, s, d, 1, 1, ns, nd, viol, cyc, got);
        total++; if (!got || si.result !== 8'h24) $display("FAIL stall_result: got %h valid %b want 24", si.result, got); else pass++;
        total++; if (viol != 0) $display("FAIL stall_pairing: got %0d want 0", viol); else pass++;
        total++; if (ns != 11 || nd != 4) $display("FAIL stall_counts: got %0d/%0d want 11/4", ns, nd); else pass++;
        release_res();
    endtask

    task automatic test_backpressure();
        bit s[$];
        bit d[$];
        int ns, nd, viol, cyc, bad;
        bit got;
        base_seed(s);
        d = '{1, 0, 0, 1};
        run_block(0, s, d, 0, 1, ns, nd, viol, cyc, got);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            st_s = (i == 5);
            @(negedge clk_in);
            if (si.result !== 8'h24 || si.result_valid !== 1'b1) bad++;
        end
        st_s = 0;
        total++; if (bad != 0) $display("FAIL hold_result: got %0d bad cycles want 0", bad); else pass++;
        total++; if (si.busy !== 1'b1) $display("FAIL hold_busy: got %b want 1", si.busy); else pass++;
        rr = 1;
        @(posedge clk_in);
        #1;
        rr = 0;
        total++; if (si.result_valid !== 1'b0 || si.busy !== 1'b0) $display("FAIL release_idle: got valid %b busy %b want 0 0", si.result_valid, si.busy); else pass++;
        total++; if (si.result !== 8'h24) $display("FAIL release_keep: got %h want 24", si.result); else pass++;
    endtask

    task automatic test_random();
        bit s[$];
        bit d[$];
        int ns, nd, viol, cyc;
        bit got;
        logic [BW-1:0] e;
        for (int n = 0; n < 4; n++) begin
            s = {};
            d = {};
            for (int i = 0; i < 11; i++) s.push_back(bit'($urandom_range(0, 1)));
            for (int i = 0; i < 4; i++) d.push_back(bit'($urandom_range(0, 1)));
            e = model(s, d, 8);
            run_block(0, s, d, 1, 1, ns, nd, viol, cyc, got);
            total++; if (!got || si.result !== e[7:0] || viol != 0) $display("FAIL random_%0d: got %h valid %b viol %0d want %h", n, si.result, got, viol, e[7:0]); else pass++;
            release_res();
        end
    endtask

    task automatic test_reset_mid();
        bit s[$];
        bit d[$];
        int ns, nd, viol, cyc;
        bit got;
        base_seed(s);
        s = s[0:9];
        d = '{1, 0};
        run_block(0, s, d, 0, 0, ns, nd, viol, cyc, got);
        total++; if (si.busy !== 1'b1) $display("FAIL midreset_pre_busy: got %b want 1", si.busy); else pass++;
        #2;
        rst = 0;
        #1;
        total++; if (si.busy !== 1'b0 || si.result_valid !== 1'b0) $display("FAIL midreset_state: got busy %b valid %b want 0 0", si.busy, si.result_valid); else pass++;
        total++; if (si.seed_ready !== 1'b0 || si.data_ready !== 1'b0) $display("FAIL midreset_ready: got %b %b want 0 0", si.seed_ready, si.data_ready); else pass++;
        total++; if (si.result !== 8'h00) $display("FAIL midreset_result: got %h want 00", si.result); else pass++;
        @(negedge clk_in);
        rst = 1;
        base_seed(s);
        d = '{1, 0, 0, 1};
        run_block(0, s, d, 0, 1, ns, nd, viol, cyc, got);
        total++; if (!got || si.result !== 8'h24) $display("FAIL after_reset_result: got %h valid %b want 24", si.result, got); else pass++;
        release_res();
    endtask

    task automatic test_default();
        bit s[$];
        bit d[$];
        int ns, nd, viol, cyc;
        bit got;
        logic [BW-1:0] e;
        for (int i = 0; i < BW + BL - 1; i++) s.push_back(bit'($urandom_range(0, 1)));
        for (int i = 0; i < BL; i++) d.push_back(bit'($urandom_range(0, 1)));
        e = model(s, d, BW);
        run_block(1, s, d, 0, 1, ns, nd, viol, cyc, got);
        total++; if (!got) $display("FAIL default_valid: got %b want 1", got); else pass++;
        total++; if (bi.result !== e) $display("FAIL default_result: got low %h want low %h", bi.result[63:0], e[63:0]); else pass++;
        total++; if (ns != 11263 || nd != BL) $display("FAIL default_counts: got %0d/%0d want 11263/%0d", ns, nd, BL); else pass++;
        total++; if (viol != 0) $display("FAIL default_pairing: got %0d want 0", viol); else pass++;
        release_res();
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        test_reset();
        test_basic();
        test_patterns();
        test_stall();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_default();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
